// File: rtl/radix4_seq_multiplier_if.sv
// Operand/result handshake bundle for radix4_seq_multiplier.
// The master side stages operands and accepts products; the slave side is the multiplier.
interface radix4_seq_multiplier_if #(
    parameter int WIDTH = 11
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/radix4_seq_multiplier.sv
// Iterative radix-4 Booth multiplier: one 3-bit multiplier window per clock,
// signed or unsigned selected per operation, valid/ready on both sides.
module radix4_seq_multiplier #(
    parameter int WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    radix4_seq_multiplier_if.slave bus
);
    localparam int NW   = WIDTH / 2 + 1;
    localparam int YW   = 2 * NW + 1;
    localparam int AW   = WIDTH + 2;
    localparam int PPW  = WIDTH + 3;
    localparam int ACCW = 2 * WIDTH + 4;
    localparam int CW   = $clog2(NW);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [AW-1:0]      r_a;
    logic [YW-1:0]      r_y;
    logic [ACCW-1:0]    r_acc;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic               w_inReady;
    logic               w_outValid;
    logic               w_busy;
    logic               w_accept;
    logic               w_lastWindow;
    logic               w_aSign;
    logic               w_bSign;
    logic               w_carry;
    logic [PPW-1:0]     w_pp;
    logic [ACCW-1:0]    w_term;
    logic [ACCW-1:0]    w_accNext;
    logic [2*NW-1:0]    w_bExt;

    assign w_aSign = bus.signed_mode & bus.a[WIDTH-1];
    assign w_bSign = bus.signed_mode & bus.b[WIDTH-1];
    assign w_bExt  = {{(2*NW-WIDTH){w_bSign}}, bus.b};

    // r_y is shifted right two bits per window, so the current triplet is always r_y[2:0].
    always_comb begin
        w_pp    = '0;
        w_carry = 1'b0;
        case (r_y[2:0])
            3'b001, 3'b010: w_pp = {r_a[AW-1], r_a};
            3'b011:         w_pp = {r_a, 1'b0};
            3'b100: begin
                w_pp    = ~{r_a, 1'b0};
                w_carry = 1'b1;
            end
            3'b101, 3'b110: begin
                w_pp    = ~{r_a[AW-1], r_a};
                w_carry = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_term       = ({{(ACCW-PPW){w_pp[PPW-1]}}, w_pp} + ACCW'(w_carry)) << {r_cnt, 1'b0};
    assign w_accNext    = r_acc + w_term;
    assign w_lastWindow = (r_cnt == CW'(NW - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_outValid  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_inReady = 1'b1;
                if (bus.in_valid) w_nextState = BUSY;
            end
            BUSY: begin
                w_busy = 1'b1;
                if (w_lastWindow) w_nextState = DONE;
            end
            DONE: begin
                w_outValid = 1'b1;
                if (bus.out_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_accept = w_inReady & bus.in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_y       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a   <= {{2{w_aSign}}, bus.a};
            r_y   <= {w_bExt, 1'b0};
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_busy) begin
            r_acc <= w_accNext;
            r_y   <= {2'b00, r_y[YW-1:2]};
            r_cnt <= r_cnt + CW'(1);
            if (w_lastWindow) r_product <= w_accNext[2*WIDTH-1:0];
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.busy      = w_busy;
    assign bus.product   = r_product;
endmodule

// File: tb/tb_radix4_seq_multiplier.sv
// Scoreboard bench for radix4_seq_multiplier: directed vectors on a WIDTH=11 instance,
// then random operations with output stalls on WIDTH=11 and WIDTH=8 instances.
module tb_radix4_seq_multiplier;
    localparam int W   = 11;
    localparam int NW  = W / 2 + 1;
    localparam int W8  = 8;
    localparam int NOPS = 1000;

    logic clk = 1'b0;
    logic rst_n;
    logic rst8_n;
    int   cyc = 0;

    int checkCount = 0;
    int passCount  = 0;
    int issued11   = 0;
    int issued8    = 0;
    int results11  = 0;
    int results8   = 0;
    bit done11     = 1'b0;
    bit done8      = 1'b0;

    longint expQ11[$];
    longint expQ8[$];

    radix4_seq_multiplier_if #(.WIDTH(W))  bus();
    radix4_seq_multiplier_if #(.WIDTH(W8)) bus8();

    radix4_seq_multiplier #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    radix4_seq_multiplier #(.WIDTH(W8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .bus   (bus8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Independent reference: plain integer multiply after explicit sign/zero extension.
    function automatic longint refProd(input longint x, input longint y, input bit sm, input int w);
        longint sx;
        longint sy;
        longint m;
        sx = x;
        sy = y;
        if (sm && x[w-1]) sx = x - (longint'(1) << w);
        if (sm && y[w-1]) sy = y - (longint'(1) << w);
        m = (longint'(1) << (2 * w)) - 1;
        return (sx * sy) & m;
    endfunction

    // Caller must be at posedge+1; returns at the acceptance edge +1 with that cycle number.
    task automatic applyStimulus(input int sel, input longint ia, input longint ib, input bit sm,
                                 input bit wantResult, input longint expected, output int acceptCyc);
        int guard;
        guard = 0;
        while (((sel == 0) ? !bus.in_ready : !bus8.in_ready) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) checkOutput("inReadyTimeout", 0, 1);
        if (sel == 0) begin
            bus.in_valid    = 1'b1;
            bus.a           = W'(ia);
            bus.b           = W'(ib);
            bus.signed_mode = sm;
            if (wantResult) begin
                expQ11.push_back(expected);
                issued11++;
            end
        end else begin
            bus8.in_valid    = 1'b1;
            bus8.a           = W8'(ia);
            bus8.b           = W8'(ib);
            bus8.signed_mode = sm;
            if (wantResult) begin
                expQ8.push_back(expected);
                issued8++;
            end
        end
        @(posedge clk);
        #1;
        acceptCyc = cyc;
        if (sel == 0) begin
            bus.in_valid    = 1'b0;
            bus.a           = W'($urandom);
            bus.b           = W'($urandom);
            bus.signed_mode = 1'($urandom);
        end else begin
            bus8.in_valid    = 1'b0;
            bus8.a           = W8'($urandom);
            bus8.b           = W8'($urandom);
            bus8.signed_mode = 1'($urandom);
        end
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            results11++;
            if (expQ11.size() == 0) checkOutput("unexpectedResult11", longint'(bus.product), -1);
            else checkOutput("product11", longint'(bus.product), expQ11.pop_front());
        end
    end

    always @(negedge clk) begin
        if (bus8.out_valid && bus8.out_ready) begin
            results8++;
            if (expQ8.size() == 0) checkOutput("unexpectedResult8", longint'(bus8.product), -1);
            else checkOutput("product8", longint'(bus8.product), expQ8.pop_front());
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int acc1;
        int acc2;
        longint ra;
        longint rb;
        bit rs;
        int guard;

        rst_n            = 1'b0;
        rst8_n           = 1'b0;
        bus.in_valid     = 1'b0;
        bus.a            = '0;
        bus.b            = '0;
        bus.signed_mode  = 1'b0;
        bus.out_ready    = 1'b1;
        bus8.in_valid    = 1'b0;
        bus8.a           = '0;
        bus8.b           = '0;
        bus8.signed_mode = 1'b0;
        bus8.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rst8_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("resetInReady", longint'(bus.in_ready), 1);
        checkOutput("resetOutValid", longint'(bus.out_valid), 0);
        checkOutput("resetBusy", longint'(bus.busy), 0);
        checkOutput("resetProduct", longint'(bus.product), 0);
        checkOutput("resetInReady8", longint'(bus8.in_ready), 1);

        $display("[TB] unsigned max x max, latency");
        applyStimulus(0, 'h7FF, 'h7FF, 1'b0, 1'b1, 'h3FF001, acc1);
        checkOutput("busyAfterAccept", longint'(bus.busy), 1);
        checkOutput("inReadyWhileBusy", longint'(bus.in_ready), 0);
        waitValid(lat);
        checkOutput("latency", lat, NW);
        @(posedge clk);
        #1;
        checkOutput("idleInReady", longint'(bus.in_ready), 1);
        checkOutput("idleOutValid", longint'(bus.out_valid), 0);

        $display("[TB] signed corner values");
        applyStimulus(0, 'h400, 'h3FF, 1'b1, 1'b1, 'h300400, acc1);
        waitValid(lat);
        @(posedge clk);
        #1;
        applyStimulus(0, 'h400, 'h400, 1'b1, 1'b1, 'h100000, acc1);
        waitValid(lat);
        @(posedge clk);
        #1;

        $display("[TB] back-to-back issue");
        applyStimulus(0, 5, 3, 1'b0, 1'b1, 15, acc1);
        applyStimulus(0, 1234, 0, 1'b0, 1'b1, 0, acc2);
        checkOutput("issueInterval", acc2 - acc1, NW + 2);
        waitValid(lat);
        @(posedge clk);
        #1;

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(0, 12, 13, 1'b0, 1'b1, 156, acc1);
        waitValid(lat);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stallProduct", longint'(bus.product), 156);
            checkOutput("stallOutValid", longint'(bus.out_valid), 1);
            checkOutput("stallInReady", longint'(bus.in_ready), 0);
            bus.in_valid    = (i == 1 || i == 2);
            bus.a           = 7;
            bus.b           = 9;
            bus.signed_mode = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("noCaptureOnHandshakeBusy", longint'(bus.busy), 0);
        checkOutput("noCaptureOnHandshakeReady", longint'(bus.in_ready), 1);
        checkOutput("noCaptureOnHandshakeValid", longint'(bus.out_valid), 0);
        expQ11.push_back(63);
        issued11++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("captureNextCycle", longint'(bus.busy), 1);
        waitValid(lat);
        @(posedge clk);
        #1;

        $display("[TB] reset mid-operation");
        applyStimulus(0, 100, 200, 1'b0, 1'b0, 0, acc1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abortOutValid", longint'(bus.out_valid), 0);
        checkOutput("abortProduct", longint'(bus.product), 0);
        checkOutput("abortInReady", longint'(bus.in_ready), 1);
        checkOutput("abortBusy", longint'(bus.busy), 0);
        rst_n = 1'b1;
        applyStimulus(0, 100, 200, 1'b0, 1'b1, 20000, acc1);
        waitValid(lat);
        checkOutput("latencyAfterAbort", lat, NW);
        @(posedge clk);
        #1;

        $display("[TB] random operations with output stalls");
        fork
            begin
                for (int i = 0; i < NOPS; i++) begin
                    ra = longint'($urandom_range(0, 2047));
                    rb = longint'($urandom_range(0, 2047));
                    rs = 1'($urandom);
                    applyStimulus(0, ra, rb, rs, 1'b1, refProd(ra, rb, rs, W), acc1);
                end
                done11 = 1'b1;
            end
            begin
                int acc8;
                longint xa;
                longint xb;
                bit xs;
                for (int i = 0; i < NOPS; i++) begin
                    xa = longint'($urandom_range(0, 255));
                    xb = longint'($urandom_range(0, 255));
                    xs = 1'($urandom);
                    applyStimulus(1, xa, xb, xs, 1'b1, refProd(xa, xb, xs, W8), acc8);
                end
                done8 = 1'b1;
            end
            begin
                while (!(done11 && done8)) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready  = ($urandom_range(0, 3) != 0);
                    bus8.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join

        bus.out_ready  = 1'b1;
        bus8.out_ready = 1'b1;
        guard = 0;
        while ((expQ11.size() != 0 || expQ8.size() != 0) && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("drain11", expQ11.size(), 0);
        checkOutput("drain8", expQ8.size(), 0);
        checkOutput("resultCount11", results11, issued11);
        checkOutput("resultCount8", results8, issued8);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
